// File: rtl/iq_stream_packer.sv
// Rounds/saturates four 28-bit I/Q lane pairs to 16 bits, packs two pairs per 64-bit word and streams them out.
// Latency 2 cycles into an empty FIFO; m_ready_i low holds the head word, a beat without room for both words is dropped.
module iq_stream_packer #(
    parameter int IN_W       = 28,
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_LEN  = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid_i,
    input  logic signed [IN_W-1:0]        inphase0_i,
    input  logic signed [IN_W-1:0]        inphase1_i,
    input  logic signed [IN_W-1:0]        inphase2_i,
    input  logic signed [IN_W-1:0]        inphase3_i,
    input  logic signed [IN_W-1:0]        quadrature0_i,
    input  logic signed [IN_W-1:0]        quadrature1_i,
    input  logic signed [IN_W-1:0]        quadrature2_i,
    input  logic signed [IN_W-1:0]        quadrature3_i,
    input  logic [3:0]                    shift_i,
    input  logic                          clear_ovf_i,
    output logic [63:0]                   m_data_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic                          m_last_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FRAME_LEN);
    localparam logic signed [IN_W:0] SAT_MAX = 32767;
    localparam logic signed [IN_W:0] SAT_MIN = -32768;

    // Round half toward +inf in IN_W+1 bits so the rounding add can never wrap.
    function automatic logic [15:0] scale(input logic signed [IN_W-1:0] x, input logic [3:0] s);
        logic signed [IN_W:0] ext;
        logic signed [IN_W:0] half;
        logic signed [IN_W:0] y;
        ext  = {x[IN_W-1], x};
        half = '0;
        if (s == 4'd0) begin
            y = ext;
        end else begin
            half = {{IN_W{1'b0}}, 1'b1} << (s - 4'd1);
            y    = (ext + half) >>> s;
        end
        if (y > SAT_MAX)
            return 16'h7fff;
        else if (y < SAT_MIN)
            return 16'h8000;
        else
            return y[15:0];
    endfunction

    logic [3:0]  s_eff;
    logic        s1_vld;
    logic [63:0] s1_a;
    logic [63:0] s1_b;

    always_comb begin
        s_eff = (shift_i > 4'd12) ? 4'd12 : shift_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_vld <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
        end else begin
            s1_vld <= in_valid_i;
            if (in_valid_i) begin
                s1_a <= {scale(quadrature1_i, s_eff), scale(inphase1_i, s_eff),
                         scale(quadrature0_i, s_eff), scale(inphase0_i, s_eff)};
                s1_b <= {scale(quadrature3_i, s_eff), scale(inphase3_i, s_eff),
                         scale(quadrature2_i, s_eff), scale(inphase2_i, s_eff)};
            end
        end
    end

    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   level;
    logic [AW-1:0] wr_addr_b;
    logic          accept;
    logic          drop;
    logic          pop;
    logic [FW-1:0] frame_cnt;

    // Free space is judged on the pre-read level, so a same-cycle pop never makes room.
    always_comb begin
        level     = wr_ptr - rd_ptr;
        accept    = s1_vld && (level <= (AW+1)'(FIFO_DEPTH - 2));
        drop      = s1_vld && !accept;
        wr_addr_b = wr_ptr[AW-1:0] + AW'(1);
        m_valid_o = (level != '0);
        pop       = m_valid_o && m_ready_i;
        m_data_o  = m_valid_o ? mem[rd_ptr[AW-1:0]] : '0;
        m_last_o  = m_valid_o && (frame_cnt == FW'(FRAME_LEN - 1));
        fifo_level_o = level;
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem[wr_ptr[AW-1:0]] <= s1_a;
            mem[wr_addr_b]      <= s1_b;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            frame_cnt  <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + (AW+1)'(2);
            if (pop) begin
                rd_ptr    <= rd_ptr + (AW+1)'(1);
                frame_cnt <= m_last_o ? '0 : frame_cnt + FW'(1);
            end
            // A drop wins over a simultaneous clear so no lost beat goes unreported.
            if (drop)
                overflow_o <= 1'b1;
            else if (clear_ovf_i)
                overflow_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_iq_stream_packer.sv
// Directed bench for iq_stream_packer with FIFO_DEPTH=16 and FRAME_LEN=4.
module tb_iq_stream_packer;
    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               in_valid_i;
    logic signed [27:0] i0, i1, i2, i3, q0, q1, q2, q3;
    logic [3:0]         shift_i;
    logic               clear_ovf_i;
    logic [63:0]        m_data_o;
    logic               m_valid_o;
    logic               m_ready_i;
    logic               m_last_o;
    logic               overflow_o;
    logic [4:0]         fifo_level_o;

    int n_checks = 0;
    int n_fail   = 0;

    iq_stream_packer #(.IN_W(28), .FIFO_DEPTH(16), .FRAME_LEN(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i),
        .inphase0_i(i0), .inphase1_i(i1), .inphase2_i(i2), .inphase3_i(i3),
        .quadrature0_i(q0), .quadrature1_i(q1), .quadrature2_i(q2), .quadrature3_i(q3),
        .shift_i(shift_i), .clear_ovf_i(clear_ovf_i),
        .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .m_last_o(m_last_o), .overflow_o(overflow_o), .fifo_level_o(fifo_level_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [63:0] exp_word(input int k, input int b);
        int base;
        base = 16 * k + 4 * b;
        return {16'(base + 3), 16'(base + 2), 16'(base + 1), 16'(base)};
    endfunction

    // Called at a negedge; presents one beat for one cycle and returns at the next negedge.
    task automatic send_beat(input logic [3:0] sh, input int v0, input int v1, input int v2,
                             input int v3, input int v4, input int v5, input int v6, input int v7);
        shift_i = sh;
        i0 = 28'(v0); q0 = 28'(v1); i1 = 28'(v2); q1 = 28'(v3);
        i2 = 28'(v4); q2 = 28'(v5); i3 = 28'(v6); q3 = 28'(v7);
        in_valid_i = 1'b1;
        @(negedge clk_i);
        in_valid_i = 1'b0;
    endtask

    task automatic fill_beats(input int first_k, input int n);
        for (int k = first_k; k < first_k + n; k++) begin
            send_beat(4'd0, 16*k, 16*k+1, 16*k+2, 16*k+3, 16*k+4, 16*k+5, 16*k+6, 16*k+7);
            @(negedge clk_i);
        end
    endtask

    // Waits (bounded) for a head word, captures it, and accepts it on the next edge.
    task automatic pop_word(output logic [63:0] d, output logic l, output bit ok);
        d = '0; l = 1'b0; ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (m_valid_o) begin
                d = m_data_o; l = m_last_o; ok = 1'b1;
                m_ready_i = 1'b1;
                @(negedge clk_i);
                m_ready_i = 1'b0;
            end else begin
                @(negedge clk_i);
            end
        end
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        in_valid_i = 1'b0; m_ready_i = 1'b0; clear_ovf_i = 1'b0; shift_i = '0;
        i0 = '0; i1 = '0; i2 = '0; i3 = '0; q0 = '0; q1 = '0; q2 = '0; q3 = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        in_valid_i = 1'b0; m_ready_i = 1'b0; clear_ovf_i = 1'b0; shift_i = '0;
        i0 = '0; i1 = '0; i2 = '0; i3 = '0; q0 = '0; q1 = '0; q2 = '0; q3 = '0;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if ({m_valid_o, m_last_o, overflow_o} !== 3'b000 || m_data_o !== 64'h0 || fifo_level_o !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid/last/ovf=%b data=%h level=%0d, need 000, 0, 0",
                     {m_valid_o, m_last_o, overflow_o}, m_data_o, fifo_level_o);
        end
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if (m_valid_o !== 1'b0 || fifo_level_o !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_release: valid=%b level=%0d, need 0 and 0", m_valid_o, fifo_level_o);
        end
    endtask

    task automatic test_rounding();
        logic [63:0] d; logic l; bit ok;
        apply_reset();
        send_beat(4'd12, 2048, -2048, 6143, -6144, 4095, -2049, 2047, -2050);
        n_checks++;
        if (m_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL latency_early: valid=%b after 1 edge, need 0", m_valid_o);
        end
        @(negedge clk_i);
        n_checks++;
        if (m_valid_o !== 1'b1 || fifo_level_o !== 5'd2) begin
            n_fail++;
            $display("FAIL latency_2: valid=%b level=%0d after 2 edges, need 1 and 2", m_valid_o, fifo_level_o);
        end
        pop_word(d, l, ok);
        n_checks++;
        if (!ok || d !== 64'hFFFF_0001_0000_0001 || l !== 1'b0) begin
            n_fail++; $display("FAIL round_word_a: got %h last=%b, need ffff000100000001 last=0", d, l);
        end
        pop_word(d, l, ok);
        n_checks++;
        if (!ok || d !== 64'hFFFF_0000_FFFF_0001) begin
            n_fail++; $display("FAIL round_word_b: got %h, need ffff0000ffff0001", d);
        end
        n_checks++;
        if (m_valid_o !== 1'b0 || fifo_level_o !== 5'd0) begin
            n_fail++; $display("FAIL round_drained: valid=%b level=%0d, need 0 and 0", m_valid_o, fifo_level_o);
        end
        send_beat(4'd1, 3, -3, 1, -1, 0, 0, 0, 0);
        pop_word(d, l, ok);
        n_checks++;
        if (!ok || d !== 64'h0000_0001_FFFF_0002) begin
            n_fail++; $display("FAIL round_shift1: got %h, need 00000001ffff0002", d);
        end
        pop_word(d, l, ok);
        n_checks++;
        if (!ok || d !== 64'h0 || l !== 1'b1) begin
            n_fail++; $display("FAIL round_shift1_b: got %h last=%b, need 0 last=1", d, l);
        end
    endtask

    task automatic test_saturation();
        logic [63:0] d; logic l; bit ok;
        apply_reset();
        send_beat(4'd0, 5, -5, -32769, 32768, 100000, -100000, 32767, -32768);
        @(negedge clk_i);
        send_beat(4'd15, 2048, -2048, 6143, -6144, 4095, -2049, 2047, -2050);
        @(negedge clk_i);
        send_beat(4'd12, 134217727, -134217728, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        pop_word(d, l, ok);
        n_checks++;
        if (!ok || d !== 64'h7FFF_8000_FFFB_0005) begin
            n_fail++; $display("FAIL sat_word_a: got %h, need 7fff8000fffb0005", d);
        end
        pop_word(d, l, ok);
        n_checks++;
        if (!ok || d !== 64'h8000_7FFF_8000_7FFF) begin
            n_fail++; $display("FAIL sat_word_b: got %h, need 80007fff80007fff", d);
        end
        pop_word(d, l, ok);
        n_checks++;
        if (!ok || d !== 64'hFFFF_0001_0000_0001) begin
            n_fail++; $display("FAIL shift15_word_a: got %h, need ffff000100000001", d);
        end
        pop_word(d, l, ok);
        n_checks++;
        if (!ok || d !== 64'hFFFF_0000_FFFF_0001) begin
            n_fail++; $display("FAIL shift15_word_b: got %h, need ffff0000ffff0001", d);
        end
        pop_word(d, l, ok);
        n_checks++;
        if (!ok || d !== 64'h0000_0000_8000_7FFF) begin
            n_fail++; $display("FAIL sat_extreme: got %h, need 0000000080007fff", d);
        end
        pop_word(d, l, ok);
    endtask

    task automatic test_overflow();
        logic [63:0] d; logic l; bit ok;
        apply_reset();
        fill_beats(0, 8);
        n_checks++;
        if (fifo_level_o !== 5'd16 || overflow_o !== 1'b0) begin
            n_fail++; $display("FAIL ovf_full: level=%0d ovf=%b, need 16 and 0", fifo_level_o, overflow_o);
        end
        fill_beats(8, 1);
        n_checks++;
        if (fifo_level_o !== 5'd16 || overflow_o !== 1'b1) begin
            n_fail++; $display("FAIL ovf_drop: level=%0d ovf=%b, need 16 and 1", fifo_level_o, overflow_o);
        end
        for (int w = 0; w < 16; w++) begin
            pop_word(d, l, ok);
            n_checks++;
            if (!ok || d !== exp_word(w / 2, w % 2) || l !== 1'((w % 4) == 3)) begin
                n_fail++;
                $display("FAIL ovf_drain_%0d: got %h last=%b, need %h last=%b",
                         w, d, l, exp_word(w / 2, w % 2), 1'((w % 4) == 3));
            end
        end
        n_checks++;
        if (m_valid_o !== 1'b0 || overflow_o !== 1'b1) begin
            n_fail++; $display("FAIL ovf_after_drain: valid=%b ovf=%b, need 0 and 1", m_valid_o, overflow_o);
        end
        clear_ovf_i = 1'b1;
        @(negedge clk_i);
        clear_ovf_i = 1'b0;
        n_checks++;
        if (overflow_o !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear: ovf=%b, need 0", overflow_o);
        end
    endtask

    task automatic test_framing();
        int idx;
        logic r;
        apply_reset();
        fill_beats(0, 4);
        idx = 0;
        for (int c = 0; c < 200 && idx < 8; c++) begin
            if (m_valid_o) begin
                n_checks++;
                if (m_data_o !== exp_word(idx / 2, idx % 2) || m_last_o !== 1'((idx % 4) == 3)) begin
                    n_fail++;
                    $display("FAIL frame_word_%0d: got %h last=%b, need %h last=%b",
                             idx, m_data_o, m_last_o, exp_word(idx / 2, idx % 2), 1'((idx % 4) == 3));
                end
            end
            r = ($urandom_range(0, 2) != 0);
            m_ready_i = r;
            if (r && m_valid_o) idx++;
            @(negedge clk_i);
        end
        m_ready_i = 1'b0;
        n_checks++;
        if (idx != 8 || m_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL frame_count: consumed %0d valid=%b, need 8 and 0", idx, m_valid_o);
        end
    endtask

    task automatic test_simultaneous();
        logic [63:0] d; logic l; bit ok;
        apply_reset();
        fill_beats(0, 8);
        pop_word(d, l, ok);
        n_checks++;
        if (!ok || fifo_level_o !== 5'd15) begin
            n_fail++; $display("FAIL simul_level15: level=%0d, need 15", fifo_level_o);
        end
        send_beat(4'd0, 1, 2, 3, 4, 5, 6, 7, 8);
        m_ready_i = 1'b1;
        @(negedge clk_i);
        m_ready_i = 1'b0;
        n_checks++;
        if (fifo_level_o !== 5'd14 || overflow_o !== 1'b1) begin
            n_fail++; $display("FAIL simul_pre_read: level=%0d ovf=%b, need 14 and 1", fifo_level_o, overflow_o);
        end
        clear_ovf_i = 1'b1;
        @(negedge clk_i);
        clear_ovf_i = 1'b0;
        fill_beats(9, 1);
        n_checks++;
        if (fifo_level_o !== 5'd16 || overflow_o !== 1'b0) begin
            n_fail++; $display("FAIL simul_refill: level=%0d ovf=%b, need 16 and 0", fifo_level_o, overflow_o);
        end
        send_beat(4'd0, 1, 2, 3, 4, 5, 6, 7, 8);
        clear_ovf_i = 1'b1;
        @(negedge clk_i);
        clear_ovf_i = 1'b0;
        n_checks++;
        if (overflow_o !== 1'b1 || fifo_level_o !== 5'd16) begin
            n_fail++; $display("FAIL simul_drop_clear: ovf=%b level=%0d, need 1 and 16", overflow_o, fifo_level_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] d; logic l; bit ok;
        apply_reset();
        fill_beats(0, 9);
        for (int w = 0; w < 10; w++) pop_word(d, l, ok);
        n_checks++;
        if (fifo_level_o !== 5'd6 || overflow_o !== 1'b1) begin
            n_fail++; $display("FAIL mid_setup: level=%0d ovf=%b, need 6 and 1", fifo_level_o, overflow_o);
        end
        #2;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if ({m_valid_o, m_last_o, overflow_o} !== 3'b000 || m_data_o !== 64'h0 || fifo_level_o !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_async_reset: valid/last/ovf=%b data=%h level=%0d, need 000, 0, 0",
                     {m_valid_o, m_last_o, overflow_o}, m_data_o, fifo_level_o);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        send_beat(4'd0, 320, 321, 322, 323, 324, 325, 326, 327);
        n_checks++;
        if (m_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL mid_latency_early: valid=%b, need 0", m_valid_o);
        end
        @(negedge clk_i);
        n_checks++;
        if (m_valid_o !== 1'b1 || fifo_level_o !== 5'd2) begin
            n_fail++; $display("FAIL mid_latency_2: valid=%b level=%0d, need 1 and 2", m_valid_o, fifo_level_o);
        end
        pop_word(d, l, ok);
        n_checks++;
        if (!ok || d !== exp_word(20, 0) || l !== 1'b0) begin
            n_fail++; $display("FAIL mid_word_a: got %h last=%b, need %h last=0", d, l, exp_word(20, 0));
        end
        pop_word(d, l, ok);
        n_checks++;
        if (!ok || d !== exp_word(20, 1) || l !== 1'b0) begin
            n_fail++; $display("FAIL mid_word_b: got %h last=%b, need %h last=0", d, l, exp_word(20, 1));
        end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_overflow();
        test_framing();
        test_simultaneous();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
